// File: rtl/vec_gather_16_pkg.sv
// Shared constants, FSM encoding and sizing helper for the vector gather block.
package vec_gather_16_pkg;
  localparam int LANES  = 16;
  localparam int WORD_W = 32;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } gstate_e;

  typedef logic [WORD_W-1:0] word_t;

  // Vector counter width; never collapses to zero bits for a 1-vector frame.
  function automatic int vec_w(input int vecs);
    return (vecs > 1) ? $clog2(vecs) : 1;
  endfunction
endpackage

// File: rtl/vec_gather_16_if.sv
// Word stream in, 16-lane vector plus frame flags out.
interface vec_gather_16_if;
  import vec_gather_16_pkg::*;

  logic                          i_valid;
  logic                          i_sof;
  word_t                         i_data;
  logic                          output_valid;
  logic                          o_sof;
  logic                          o_frame_done;
  logic                          o_err;
  // data_out[k] is lane k, i.e. the k-th word of the vector
  logic [LANES-1:0][WORD_W-1:0]  data_out;

  modport master (
    output i_valid, i_sof, i_data,
    input  output_valid, o_sof, o_frame_done, o_err, data_out
  );

  modport slave (
    input  i_valid, i_sof, i_data,
    output output_valid, o_sof, o_frame_done, o_err, data_out
  );
endinterface

// File: rtl/gather_frame_ctrl.sv
// Frame/lane sequencing: FSM, lane and vector counters, output strobes, sticky error.
module gather_frame_ctrl
  import vec_gather_16_pkg::*;
#(
  parameter int VECS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_sof,
  output logic              lane_we,
  output logic [LANE_W-1:0] lane_idx,
  output logic              bank_ld,
  output logic              output_valid,
  output logic              o_sof,
  output logic              o_frame_done,
  output logic              o_err
);
  localparam int VW = vec_w(VECS);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [VW-1:0]     VEC_LAST  = VW'(VECS - 1);

  gstate_e           state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic              err_set;
  logic              vec_last;

  assign vec_last = (vec_q == VEC_LAST);

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      vec_q   <= vec_d;
    end
  end

  // Next-state, counter update and lane write decode
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    vec_d    = vec_q;
    err_set  = 1'b0;
    lane_we  = 1'b0;
    lane_idx = lane_q;
    bank_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_sof) begin
            state_d  = COLLECT;
            lane_we  = 1'b1;
            lane_idx = '0;
            lane_d   = LANE_W'(1);
            vec_d    = '0;
          end else begin
            // word outside any frame: dropped
            err_set = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (i_valid) begin
          if (i_sof) begin
            // restart; a partial vector in flight is abandoned and flagged,
            // a restart exactly on a vector boundary is legal
            lane_we  = 1'b1;
            lane_idx = '0;
            lane_d   = LANE_W'(1);
            vec_d    = '0;
            err_set  = (lane_q != '0);
          end else begin
            lane_we = 1'b1;
            lane_d  = lane_q + LANE_W'(1);
            if (lane_q == LANE_LAST) begin
              bank_ld = 1'b1;
              if (vec_last) begin
                vec_d   = '0;
                state_d = IDLE;
              end else begin
                vec_d = vec_q + VW'(1);
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered strobes aligned with the output bank, plus sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      output_valid <= bank_ld;
      o_sof        <= bank_ld & (vec_q == '0);
      o_frame_done <= bank_ld & vec_last;
      o_err        <= o_err | err_set;
    end
  end
endmodule

// File: rtl/vec_gather_16.sv
// Serial-to-parallel gather: packs 16 consecutive words into one vector for sum_16.
module vec_gather_16
  import vec_gather_16_pkg::*;
#(
  parameter int input_x = 4,
  parameter int input_y = 4
) (
  input  logic            clk,
  input  logic            rst,
  vec_gather_16_if.slave  bus
);
  localparam int VECS = input_x * input_y;

  logic                         lane_we;
  logic [LANE_W-1:0]            lane_idx;
  logic                         bank_ld;
  // lanes 0..14 only; lane 15 goes straight from i_data into the bank
  logic [LANES-2:0][WORD_W-1:0] shadow;
  logic [LANES-1:0][WORD_W-1:0] bank_q;

  gather_frame_ctrl #(.VECS(VECS)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (bus.i_valid),
    .i_sof        (bus.i_sof),
    .lane_we      (lane_we),
    .lane_idx     (lane_idx),
    .bank_ld      (bank_ld),
    .output_valid (bus.output_valid),
    .o_sof        (bus.o_sof),
    .o_frame_done (bus.o_frame_done),
    .o_err        (bus.o_err)
  );

  genvar k;
  generate
    for (k = 0; k < LANES - 1; k++) begin : g_shadow
      // Per-lane shadow write, selected by the current lane index
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          shadow[k] <= '0;
        else if (lane_we && lane_idx == LANE_W'(k))
          shadow[k] <= bus.i_data;
      end
    end
  endgenerate

  // Output bank captures the whole vector only on completion and holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bank_q <= '0;
    else if (bank_ld)
      bank_q <= {bus.i_data, shadow};
  end

  assign bus.data_out = bank_q;
endmodule

// File: tb/tb_vec_gather_16.sv
// Directed self-checking bench for vec_gather_16 (default 4x4 frame).
module tb_vec_gather_16;
  import vec_gather_16_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  vec_gather_16_if bus();

  vec_gather_16 #(.input_x(4), .input_y(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // FP32 encodings of 1.0 .. 16.0
  word_t fp1 [LANES] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
  };
  word_t exp_lane [LANES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic ov, input logic sof,
                           input logic done, input logic err);
    chk({tag, " output_valid"}, 32'(bus.output_valid), 32'(ov));
    chk({tag, " o_sof"},        32'(bus.o_sof),        32'(sof));
    chk({tag, " o_frame_done"}, 32'(bus.o_frame_done), 32'(done));
    chk({tag, " o_err"},        32'(bus.o_err),        32'(err));
  endtask

  task automatic chk_lanes(input string tag);
    for (int k = 0; k < LANES; k++)
      chk($sformatf("%s lane%0d", tag, k), bus.data_out[k], exp_lane[k]);
  endtask

  // Drive one cycle of input; returns 1 time unit after the capturing edge
  task automatic cyc(input logic v, input logic s, input word_t d);
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    word_t w;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_data  = '0;
    for (int k = 0; k < LANES; k++) exp_lane[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_lanes("reset");
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);

    // single vector 1.0 .. 16.0
    for (int k = 0; k < LANES; k++) begin
      cyc(1'b1, k == 0, fp1[k]);
      exp_lane[k] = fp1[k];
      if (k < LANES - 1) chk("t1 early ov", 32'(bus.output_valid), 32'd0);
    end
    chk_flags("t1 strobe", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_lanes("t1");
    cyc(1'b0, 1'b0, '0);
    chk_flags("t1 after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_lanes("t1 hold");

    // full 4x4 frame, continuous; restart on a vector boundary is not an error
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < LANES; k++) begin
        w = 32'hC000_0000 | (32'(v) << 8) | 32'(k);
        cyc(1'b1, (v == 0) && (k == 0), w);
        exp_lane[k] = w;
        chk($sformatf("t2 v%0d k%0d ov", v, k), 32'(bus.output_valid), 32'(k == LANES - 1));
        if (k == LANES - 1) begin
          chk($sformatf("t2 v%0d sof", v),  32'(bus.o_sof),        32'(v == 0));
          chk($sformatf("t2 v%0d done", v), 32'(bus.o_frame_done), 32'(v == 15));
          chk_lanes($sformatf("t2 v%0d", v));
        end
      end
    end
    chk("t2 err", 32'(bus.o_err), 32'd0);

    // frame ended -> IDLE: a word without sof is dropped and flagged
    cyc(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_flags("t4 idle word", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_lanes("t4 hold");

    // bubbles inside a vector
    for (int k = 0; k < LANES; k++) begin
      w = 32'h5A5A_0000 | 32'(k);
      cyc(1'b1, k == 0, w);
      exp_lane[k] = w;
      if (k < LANES - 1) begin
        chk($sformatf("t3 k%0d ov", k), 32'(bus.output_valid), 32'd0);
        if (k % 3 == 1) cyc(1'b0, 1'b1, 32'hFFFF_FFFF);
        if (k == 9) repeat (3) cyc(1'b0, 1'b0, 32'h1234_5678);
        chk($sformatf("t3 bub%0d ov", k), 32'(bus.output_valid), 32'd0);
      end
    end
    chk_flags("t3 strobe", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_lanes("t3");

    // sof at lane 7 discards the partial vector
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, k == 0, 32'h7777_0000 | 32'(k));
      chk($sformatf("t5 part%0d ov", k), 32'(bus.output_valid), 32'd0);
    end
    for (int k = 0; k < LANES; k++) begin
      w = 32'h3C00_0000 | 32'(k);
      cyc(1'b1, k == 0, w);
      exp_lane[k] = w;
      if (k < LANES - 1) chk($sformatf("t5 k%0d ov", k), 32'(bus.output_valid), 32'd0);
    end
    chk_flags("t5 strobe", 1'b1, 1'b1, 1'b0, 1'b1);
    chk_lanes("t5");

    // asynchronous reset at lane_cnt=10
    for (int k = 0; k < 10; k++) cyc(1'b1, k == 0, 32'h6666_0000 | 32'(k));
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < LANES; k++) exp_lane[k] = '0;
    chk_flags("t6 rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_lanes("t6 rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, '0);
      chk("t6 no strobe", 32'(bus.output_valid), 32'd0);
    end
    for (int k = 0; k < LANES; k++) begin
      w = fp1[LANES - 1 - k];
      cyc(1'b1, k == 0, w);
      exp_lane[k] = w;
    end
    chk_flags("t6 strobe", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_lanes("t6");

    // words with no sof after reset: never a strobe, error sticks
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < LANES; k++) exp_lane[k] = '0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b0, 32'hABCD_0000 | 32'(k));
      chk_flags($sformatf("t7 w%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    repeat (3) cyc(1'b0, 1'b0, '0);
    chk("t7 err sticky", 32'(bus.o_err), 32'd1);
    chk_lanes("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vec_gather_16.md
# vec_gather_16

Serial-to-parallel front end for the 16-input FP32 adder tree (`sum_16`). It accepts a stream of 32-bit words, one per cycle, with a start-of-frame marker. It packs each run of 16 consecutive words into a 16-lane vector and presents the vector with a single-cycle `output_valid` strobe. It also tracks vector position within a frame of `input_x*input_y` vectors, so downstream blocks see frame-start and frame-end flags aligned to the data.

## Interface
- `input_x`, default 4: frame width in vectors.
- `input_y`, default 4: frame height in vectors; `VECS = input_x*input_y` vectors per frame.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_valid`  in  1  `i_data` valid this cycle.
- `i_sof`  in  1  qualifies the current word as word 0 of a new frame; ignored when `i_valid`=0.
- `i_data`  in  32  input word, FP32 bit pattern, passed bit-exact.
- `output_valid`  out  1  one-cycle strobe; a new vector is on `data_out_*`.
- `data_out_0` … `data_out_15`  out  32 each  vector lanes; lane k = k-th word of the vector.
- `o_sof`  out  1  high with `output_valid` when the vector is index 0 of its frame.
- `o_frame_done`  out  1  high with `output_valid` when the vector is index `VECS-1`.
- `o_err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- FSM states:
  - IDLE: wait for a frame start. `i_valid & i_sof` moves to COLLECT, writes the word to lane 0, and sets lane_cnt=1, vec_cnt=0. `i_valid & !i_sof` drops the word and sets `o_err`.
  - COLLECT: each `i_valid` word is written to shadow[lane_cnt], then lane_cnt increments.
- Vector completion: when `i_valid` and lane_cnt=15, load shadow[0..14] plus the current word (lane 15) into the output bank. Next cycle, `output_valid`=1 with `o_sof`=(vec_cnt==0) and `o_frame_done`=(vec_cnt==VECS-1). lane_cnt wraps to 0. vec_cnt increments, or returns to 0 with FSM→IDLE on the last vector.
- Mid-frame `i_valid & i_sof` in COLLECT with lane_cnt≠0:
  - Discard the partial vector and set `o_err`.
  - Treat the word as lane 0 of a new frame: lane_cnt=1, vec_cnt=0.
- `i_sof` at lane_cnt=0 in COLLECT (frame restarted on a vector boundary): restart the frame with vec_cnt=0. `o_err` is not set.
- `i_valid`=0 cycles are bubbles; counters hold and shadow is unchanged.
- `data_out_*` holds its value between strobes; the output bank updates only at vector completion.
- Reset mid-operation: FSM→IDLE, counters 0, the partial vector is lost, no strobe is emitted.
- Counter widths: lane_cnt 4 bits; vec_cnt `max(1,$clog2(VECS))` bits.

## Timing
- Reset values: `output_valid`=0, `o_sof`=0, `o_frame_done`=0, `o_err`=0, all `data_out_k`=0, FSM=IDLE.
- Latency: `output_valid` rises exactly 1 cycle after the cycle that accepts the 16th word.
- Throughput: one word per cycle, no backpressure, no stall. Strobes are at least 16 cycles apart; back-to-back vectors need no gap cycle.
- `output_valid`, `o_sof`, `o_frame_done` are single-cycle pulses, registered, with no combinational path from inputs.
- A completion and a new-frame `i_sof` in the same cycle are impossible: the completing word has lane_cnt=15, and sof at lane_cnt≠0 takes the discard path, so no strobe is emitted.

## Structure
- Shared package holds `LANES`=16, `WORD_W`=32, and the FSM state encodings (IDLE=0, COLLECT=1).
- Sub-module `gather_frame_ctrl` contains the FSM, lane_cnt, vec_cnt, and the flag/`o_err` generation. The top level holds the shadow and output register banks and the lane write decode.

## Test plan
- After reset, stream 16 words 0x3F800000 … (k+1).0 with `i_sof` on word 0 → one strobe 1 cycle after word 15; lane k = FP32(k+1); `o_sof`=1; `o_err`=0.
- Default 4×4: stream 256 words continuously, sof on word 0 → 16 strobes spaced 16 cycles apart; `o_sof` on strobe 1 only; `o_frame_done` on strobe 16; FSM back to IDLE.
- Insert random `i_valid`=0 bubbles inside a vector → identical lane data; strobe 1 cycle after the 16th valid word.
- `i_valid` words with no `i_sof` after reset → no strobe; `o_err`=1 and it stays 1.
- `i_sof` at lane_cnt=7 → partial discarded, `o_err`=1; the next 16 words form a vector with `o_sof`=1.
- Assert `rst` at lane_cnt=10 → all outputs 0 immediately; a following sof-led vector is gathered correctly.
